zx_port_mapper: RTL and testbench
=================================

# zx_port_mapper

Parametrised ZX Spectrum 128/Pentagon memory-paging and I/O port latch unit, sitting between the Z80 bus and the RAM/ROM/video blocks of the DE0 top level. It detects CPU port writes once per bus cycle, maintains the 7FFD paging register (extended to 512k), the FE border/speaker latch and, optionally, the AY register-select latch. It translates every CPU address into a physical RAM/ROM address and selects the screen bank for the video unit.

## Interface
- RAM_BANK_BITS, 3, bank-number width; 3 = 128k, 4 = 256k, 5 = 512k (legal 3..5)
- FULL_DECODE, 1, 1 = 7FFD matched on all 16 address bits; 0 = Pentagon partial decode (A15=0, A1=0)
- clock_25  in  1  block clock, 25 MHz
- RESET_N  in  1  synchronous, active-low reset
- A  in  16  CPU address bus
- D_in  in  8  CPU data bus (write direction)
- nMREQ, nIORQ, nRD, nWR  in  1 each  Z80 bus strobes, asynchronous to clock_25
- mem_addr  out  RAM_BANK_BITS+14  physical RAM address
- rom_addr  out  15  ROM address (page bit + A[13:0])
- rom_sel  out  1  1 when A[15:14]=00
- ram_we  out  1  RAM write enable
- vid_bank7  out  1  1 = video reads bank 7, 0 = bank 5
- border  out  3  border colour
- speaker  out  1  beeper output
- paging  out  8  current 7FFD register value
- ay_addr  out  4  AY selected register (ZX_AY_DECODE_EN only)
- ay_wr  out  1  one-cycle AY data-write strobe
- ay_data  out  8  data captured with ay_wr

## Operation
- Raw I/O write = !nIORQ & nRD & !nWR. Stage 1 registers raw, A, D_in; stage 2 registers stage-1 strobe. Decode pulse = stage1 & !stage2, i.e. exactly one pulse per bus write regardless of its length.
- Decode on pulse, using the stage-1 A/D captures; priority order:
  - 7FFD (per FULL_DECODE) and lock (paging[5]) clear: paging <= D; ext bank bits <= D[7:6] truncated to RAM_BANK_BITS-3 (none for 3). Lock set: write ignored.
  - FFFD: ay_addr <= D[3:0]. BFFD: ay_wr pulse, ay_data <= D.
  - Else A[0]=0: border <= D[2:0]; speaker <= D[4]^D[3].
- Address map (combinational from live A and registered state, zero latency):
  - 0000-3FFF: rom_sel=1, rom_addr = {paging[4]|paging[5], A[13:0]}.
  - 4000-7FFF: bank 5; 8000-BFFF: bank 2; C000-FFFF: lock ? bank 0 : {ext, paging[2:0]}.
  - mem_addr = {bank zero-extended to RAM_BANK_BITS, A[13:0]}.
- ram_we = !nMREQ & nRD & !nWR & (A[15:14] != 00); writes to ROM space never reach RAM.
- vid_bank7 = paging[3], independent of lock.

## Timing
- Reset (RESET_N low at clock_25 edge): paging=0, ext=0, border=0, speaker=0, ay_addr=0, ay_wr=0, ay_data=0, sync stages=0. Lock is cleared only by reset.
- Port-write latency: register visible 2 clock_25 edges after raw strobe first sampled high.
- Minimum strobe width: 1 clock_25 period (40 ns); shorter writes may be lost.
- Reset asserted mid-write: reset wins; no pulse generated for that write after release unless strobe re-rises (stage 2 also reset, so a still-held strobe produces one pulse after release).
- Back-to-back writes need the strobe low for at least one sampled cycle between them.
- ay_wr high exactly one cycle.

## Configuration
- ZX_AY_DECODE_EN defined: FFFD/BFFD decoded as above and excluded from FE decode.
- Undefined: ay_addr, ay_wr, ay_data tied 0; FFFD/BFFD fall through to the A[0]=0 FE rule (A[0]=1, so no effect).

## Structure
- Shared package zx_pkg: port constants (PORT_7FFD, PORT_FFFD, PORT_BFFD), fixed bank numbers (BANK_SCREEN=5, BANK_MID=2, BANK_SHADOW=7), paging bit positions (PG_LOCK=5, PG_ROM=4, PG_SCREEN=3).
- One sub-module: zx_io_strobe (2-stage capture + rising-edge pulse, A/D capture).

## Test plan
- Reset, write 7FFD=0x07, read C123 -> mem_addr bank 7 (0x1C123 at RAM_BANK_BITS=3); vid_bank7=0.
- Write 7FFD=0x30 (lock+ROM1), then 7FFD=0x03 -> paging stays 0x30, C000 maps bank 0, rom_addr[14]=1.
- RAM_BANK_BITS=5, write 7FFD=0xC1 -> C000 maps bank 25 (0x18 | 1), mem_addr=0x64000.
- Write port FE=0x15, nWR held 10 cycles -> border=5, speaker=1, one decode pulse only.
- ZX_AY_DECODE_EN: FFFD=0x07 then BFFD=0x3E -> ay_addr=7, ay_wr single pulse, ay_data=0x3E.
- Memory write to 0x1234 -> ram_we=0; to 0x4000 -> ram_we=1, mem_addr bank 5.

Source files
------------

// File: rtl/zx_pkg.sv
// zx_pkg: port numbers, fixed bank numbers and paging-register bit positions for the Spectrum 128/Pentagon mapper
package zx_pkg;
  localparam logic [15:0] PORT_7FFD = 16'h7FFD;
  localparam logic [15:0] PORT_FFFD = 16'hFFFD;
  localparam logic [15:0] PORT_BFFD = 16'hBFFD;
  localparam int BANK_SCREEN = 5;
  localparam int BANK_MID    = 2;
  localparam int BANK_SHADOW = 7;
  localparam int PG_LOCK   = 5;
  localparam int PG_ROM    = 4;
  localparam int PG_SCREEN = 3;
  typedef enum logic [1:0] {
    SEG_ROM    = 2'b00,
    SEG_SCREEN = 2'b01,
    SEG_MID    = 2'b10,
    SEG_TOP    = 2'b11
  } seg_e;
  function automatic logic is_7ffd(input logic [15:0] a, input bit full);
    return full ? (a == PORT_7FFD) : (!a[15] && !a[1]);
  endfunction
endpackage

// File: rtl/zx_io_strobe.sv
// zx_io_strobe: two-stage capture of the asynchronous Z80 I/O write strobe, emitting one pulse per bus write with the A/D sampled alongside
module zx_io_strobe (
  input  logic        clock_25,
  input  logic        RESET_N,
  input  logic        wr_raw_i,
  input  logic [15:0] a_i,
  input  logic [7:0]  d_i,
  output logic        pulse_o,
  output logic [15:0] a_o,
  output logic [7:0]  d_o
);
  logic        s1_q, s2_q;
  logic [15:0] a_q;
  logic [7:0]  d_q;
  // stage 1 samples strobe with bus, stage 2 delays the strobe so only its first sampled cycle pulses
  always_ff @(posedge clock_25) begin
    if (!RESET_N) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      a_q  <= '0;
      d_q  <= '0;
    end else begin
      s1_q <= wr_raw_i;
      s2_q <= s1_q;
      a_q  <= a_i;
      d_q  <= d_i;
    end
  end
  assign pulse_o = s1_q & ~s2_q;
  assign a_o     = a_q;
  assign d_o     = d_q;
endmodule

// File: rtl/zx_port_mapper.sv
// zx_port_mapper: 7FFD paging (up to 512k), FE border/beeper latch and CPU-to-RAM/ROM address translation; AY select/data decode under ZX_AY_DECODE_EN
module zx_port_mapper
  import zx_pkg::*;
#(
  parameter int unsigned RAM_BANK_BITS = 3,
  parameter bit          FULL_DECODE   = 1'b1
) (
  input  logic                     clock_25,
  input  logic                     RESET_N,
  input  logic [15:0]              A,
  input  logic [7:0]               D_in,
  input  logic                     nMREQ,
  input  logic                     nIORQ,
  input  logic                     nRD,
  input  logic                     nWR,
  output logic [RAM_BANK_BITS+13:0] mem_addr,
  output logic [14:0]              rom_addr,
  output logic                     rom_sel,
  output logic                     ram_we,
  output logic                     vid_bank7,
  output logic [2:0]               border,
  output logic                     speaker,
  output logic [7:0]               paging,
  output logic [3:0]               ay_addr,
  output logic                     ay_wr,
  output logic [7:0]               ay_data
);
  logic                     io_pulse;
  logic [15:0]              io_a;
  logic [7:0]               io_d;
  logic                     hit_pg, do_fe;
  logic [7:0]               paging_q, paging_d;
  logic [2:0]               border_q, border_d;
  logic                     speaker_q, speaker_d;
  logic [RAM_BANK_BITS-1:0] bank;
  zx_io_strobe u_strobe (
    .clock_25 (clock_25),
    .RESET_N  (RESET_N),
    .wr_raw_i (!nIORQ & nRD & !nWR),
    .a_i      (A),
    .d_i      (D_in),
    .pulse_o  (io_pulse),
    .a_o      (io_a),
    .d_o      (io_d)
  );
  assign hit_pg = is_7ffd(io_a, FULL_DECODE);
`ifdef ZX_AY_DECODE_EN
  logic       do_sel, do_dat;
  logic [3:0] ay_addr_q, ay_addr_d;
  logic [7:0] ay_data_q, ay_data_d;
  logic       ay_wr_q, ay_wr_d;
  // AY register select and data write sit below 7FFD in priority and above the FE latch
  always_comb begin
    do_sel    = io_pulse && !hit_pg && io_a == PORT_FFFD;
    do_dat    = io_pulse && !hit_pg && io_a == PORT_BFFD;
    do_fe     = io_pulse && !hit_pg && !do_sel && !do_dat && !io_a[0];
    ay_addr_d = do_sel ? io_d[3:0] : ay_addr_q;
    ay_data_d = do_dat ? io_d : ay_data_q;
    ay_wr_d   = do_dat;
  end
  // AY latches; the write strobe lasts exactly the cycle after the decode pulse
  always_ff @(posedge clock_25) begin
    if (!RESET_N) begin
      ay_addr_q <= '0;
      ay_data_q <= '0;
      ay_wr_q   <= 1'b0;
    end else begin
      ay_addr_q <= ay_addr_d;
      ay_data_q <= ay_data_d;
      ay_wr_q   <= ay_wr_d;
    end
  end
  assign ay_addr = ay_addr_q;
  assign ay_data = ay_data_q;
  assign ay_wr   = ay_wr_q;
`else
  assign do_fe   = io_pulse && !hit_pg && !io_a[0];
  assign ay_addr = '0;
  assign ay_data = '0;
  assign ay_wr   = 1'b0;
`endif
  // once the lock bit is set, 7FFD writes are dropped until reset
  always_comb begin
    paging_d  = (io_pulse && hit_pg && !paging_q[PG_LOCK]) ? io_d : paging_q;
    border_d  = do_fe ? io_d[2:0] : border_q;
    speaker_d = do_fe ? (io_d[4] ^ io_d[3]) : speaker_q;
  end
  // paging and border/beeper registers
  always_ff @(posedge clock_25) begin
    if (!RESET_N) begin
      paging_q  <= '0;
      border_q  <= '0;
      speaker_q <= 1'b0;
    end else begin
      paging_q  <= paging_d;
      border_q  <= border_d;
      speaker_q <= speaker_d;
    end
  end
  // top 16k bank: the extended bits are paging[7:6] trimmed to what the RAM size needs; lock forces bank 0
  always_comb begin
    bank = (A[15:14] == SEG_SCREEN) ? RAM_BANK_BITS'(BANK_SCREEN) :
           (A[15:14] == SEG_MID)    ? RAM_BANK_BITS'(BANK_MID) :
           paging_q[PG_LOCK]        ? '0 :
                                      RAM_BANK_BITS'({paging_q[7:6], paging_q[2:0]});
  end
  assign mem_addr  = {bank, A[13:0]};
  assign rom_sel   = A[15:14] == SEG_ROM;
  assign rom_addr  = {paging_q[PG_ROM] | paging_q[PG_LOCK], A[13:0]};
  assign ram_we    = !nMREQ & nRD & !nWR & (A[15:14] != SEG_ROM);
  assign vid_bank7 = paging_q[PG_SCREEN];
  assign border    = border_q;
  assign speaker   = speaker_q;
  assign paging    = paging_q;
endmodule

// File: tb/tb_zx_port_mapper.sv
// tb_zx_port_mapper: table-driven port-write vectors through a scoreboard queue on a 128k full-decode and a 512k Pentagon instance, plus reset/back-to-back/RAM-write sequences
module tb_zx_port_mapper;
`ifdef ZX_AY_DECODE_EN
  localparam bit AY = 1'b1;
`else
  localparam bit AY = 1'b0;
`endif
  typedef struct {
    logic [15:0] a;
    logic [7:0]  d;
    int          len;
    logic [7:0]  pg3;
    logic [7:0]  pg5;
    logic [2:0]  brd;
    logic        spk;
    logic        vid3;
    logic        vid5;
    logic [15:0] rd;
    logic [16:0] m3;
    logic [18:0] m5;
    logic        r14;
    logic [3:0]  aya;
    logic [7:0]  ayd;
    int          wr;
  } vec_t;
  localparam int NV = 12;
  logic clk = 1'b0;
  logic rst_n;
  logic [15:0] A;
  logic [7:0] D;
  logic nMREQ, nIORQ, nRD, nWR;
  logic [16:0] mem3;
  logic [18:0] mem5;
  logic [14:0] rom3, rom5;
  logic rsel3, rsel5, we3, we5, vid3, vid5, spk3, spk5, aw3, aw5;
  logic [2:0] brd3, brd5;
  logic [7:0] pg3, pg5, ad3, ad5;
  logic [3:0] aa3, aa5;
  int checks = 0;
  int errors = 0;
  int wr3 = 0;
  int wr5 = 0;
  vec_t vecs[NV];
  vec_t sbq[$];
  vec_t e;
  always #20 clk = ~clk;
  zx_port_mapper #(.RAM_BANK_BITS(3), .FULL_DECODE(1'b1)) u3 (
    .clock_25(clk), .RESET_N(rst_n), .A(A), .D_in(D), .nMREQ(nMREQ), .nIORQ(nIORQ), .nRD(nRD), .nWR(nWR),
    .mem_addr(mem3), .rom_addr(rom3), .rom_sel(rsel3), .ram_we(we3), .vid_bank7(vid3), .border(brd3),
    .speaker(spk3), .paging(pg3), .ay_addr(aa3), .ay_wr(aw3), .ay_data(ad3));
  zx_port_mapper #(.RAM_BANK_BITS(5), .FULL_DECODE(1'b0)) u5 (
    .clock_25(clk), .RESET_N(rst_n), .A(A), .D_in(D), .nMREQ(nMREQ), .nIORQ(nIORQ), .nRD(nRD), .nWR(nWR),
    .mem_addr(mem5), .rom_addr(rom5), .rom_sel(rsel5), .ram_we(we5), .vid_bank7(vid5), .border(brd5),
    .speaker(spk5), .paging(pg5), .ay_addr(aa5), .ay_wr(aw5), .ay_data(ad5));
  always @(negedge clk) begin
    if (aw3) wr3++;
    if (aw5) wr5++;
  end
  task automatic check(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", n, act, exp);
    end
  endtask
  task automatic io_wr(input logic [15:0] a, input logic [7:0] d, input int len);
    @(negedge clk);
    A = a; D = d; nIORQ = 1'b0; nWR = 1'b0;
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      if (i == 2) D = 8'h00;
    end
    nIORQ = 1'b1; nWR = 1'b1;
    repeat (3) @(negedge clk);
  endtask
  initial begin
    vecs[0]  = '{16'h7FFD, 8'h07, 2,  8'h07, 8'h07, 3'd0, 1'b0, 1'b0, 1'b0, 16'hC123, 17'h1C123, 19'h1C123, 1'b0, 4'h0, 8'h00, 0};
    vecs[1]  = '{16'h00FE, 8'h15, 10, 8'h07, 8'h07, 3'd5, 1'b1, 1'b0, 1'b0, 16'h4000, 17'h14000, 19'h14000, 1'b0, 4'h0, 8'h00, 0};
    vecs[2]  = '{16'h7FFD, 8'hC1, 2,  8'hC1, 8'hC1, 3'd5, 1'b1, 1'b0, 1'b0, 16'hC000, 17'h04000, 19'h64000, 1'b0, 4'h0, 8'h00, 0};
    vecs[3]  = '{16'h7FFD, 8'h0A, 3,  8'h0A, 8'h0A, 3'd5, 1'b1, 1'b1, 1'b1, 16'hFFFF, 17'h0BFFF, 19'h0BFFF, 1'b0, 4'h0, 8'h00, 0};
    vecs[4]  = '{16'h1FFD, 8'h04, 2,  8'h0A, 8'h04, 3'd5, 1'b1, 1'b1, 1'b0, 16'hC000, 17'h08000, 19'h10000, 1'b0, 4'h0, 8'h00, 0};
    vecs[5]  = '{16'h7FFD, 8'h0A, 2,  8'h0A, 8'h0A, 3'd5, 1'b1, 1'b1, 1'b1, 16'h8000, 17'h08000, 19'h08000, 1'b0, 4'h0, 8'h00, 0};
    vecs[6]  = '{16'h00FE, 8'h18, 2,  8'h0A, 8'h0A, 3'd0, 1'b0, 1'b1, 1'b1, 16'h8000, 17'h08000, 19'h08000, 1'b0, 4'h0, 8'h00, 0};
    vecs[7]  = '{16'hFFFD, 8'h07, 2,  8'h0A, 8'h0A, 3'd0, 1'b0, 1'b1, 1'b1, 16'h8000, 17'h08000, 19'h08000, 1'b0, 4'h7, 8'h00, 0};
    vecs[8]  = '{16'hBFFD, 8'h3E, 2,  8'h0A, 8'h0A, 3'd0, 1'b0, 1'b1, 1'b1, 16'h8000, 17'h08000, 19'h08000, 1'b0, 4'h7, 8'h3E, 1};
    vecs[9]  = '{16'h7FFD, 8'h30, 2,  8'h30, 8'h30, 3'd0, 1'b0, 1'b0, 1'b0, 16'hC001, 17'h00001, 19'h00001, 1'b1, 4'h7, 8'h3E, 0};
    vecs[10] = '{16'h7FFD, 8'h03, 2,  8'h30, 8'h30, 3'd0, 1'b0, 1'b0, 1'b0, 16'hC001, 17'h00001, 19'h00001, 1'b1, 4'h7, 8'h3E, 0};
    vecs[11] = '{16'h00FE, 8'h0F, 4,  8'h30, 8'h30, 3'd7, 1'b1, 1'b0, 1'b0, 16'hC001, 17'h00001, 19'h00001, 1'b1, 4'h7, 8'h3E, 0};
    rst_n = 1'b0; A = 16'h0123; D = 8'h00; nMREQ = 1'b1; nIORQ = 1'b1; nRD = 1'b1; nWR = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    check("rst paging3", pg3, 8'h00);
    check("rst paging5", pg5, 8'h00);
    check("rst border3", brd3, 3'd0);
    check("rst speaker3", spk3, 1'b0);
    check("rst vid3", vid3, 1'b0);
    check("rst ay_addr3", aa3, 4'h0);
    check("rst ay_data3", ad3, 8'h00);
    check("rst ay_wr3", aw3, 1'b0);
    check("rst rom_sel3", rsel3, 1'b1);
    check("rst rom_addr3", rom3, 15'h0123);
    A = 16'hC123;
    #1;
    check("rst mem3", mem3, 17'h00123);
    check("rst mem5", mem5, 19'h00123);
    for (int i = 0; i < NV; i++) begin
      wr3 = 0; wr5 = 0;
      sbq.push_back(vecs[i]);
      io_wr(vecs[i].a, vecs[i].d, vecs[i].len);
      e = sbq.pop_front();
      check($sformatf("v%0d paging3", i), pg3, e.pg3);
      check($sformatf("v%0d paging5", i), pg5, e.pg5);
      check($sformatf("v%0d border3", i), brd3, e.brd);
      check($sformatf("v%0d border5", i), brd5, e.brd);
      check($sformatf("v%0d speaker3", i), spk3, e.spk);
      check($sformatf("v%0d speaker5", i), spk5, e.spk);
      check($sformatf("v%0d vid3", i), vid3, e.vid3);
      check($sformatf("v%0d vid5", i), vid5, e.vid5);
      check($sformatf("v%0d ay_addr3", i), aa3, AY ? e.aya : 4'h0);
      check($sformatf("v%0d ay_addr5", i), aa5, AY ? e.aya : 4'h0);
      check($sformatf("v%0d ay_data3", i), ad3, AY ? e.ayd : 8'h00);
      check($sformatf("v%0d ay_wr_cycles3", i), wr3, AY ? e.wr : 0);
      check($sformatf("v%0d ay_wr_cycles5", i), wr5, AY ? e.wr : 0);
      A = e.rd; nMREQ = 1'b0; nRD = 1'b0;
      #1;
      check($sformatf("v%0d mem3", i), mem3, e.m3);
      check($sformatf("v%0d mem5", i), mem5, e.m5);
      check($sformatf("v%0d rom14_3", i), rom3[14], e.r14);
      check($sformatf("v%0d rom14_5", i), rom5[14], e.r14);
      check($sformatf("v%0d ram_we_rd", i), we3, 1'b0);
      nMREQ = 1'b1; nRD = 1'b1;
    end
    @(negedge clk);
    rst_n = 1'b0; A = 16'h00FE; D = 8'h02; nIORQ = 1'b0; nWR = 1'b0;
    repeat (2) @(negedge clk);
    check("midrst border3", brd3, 3'd0);
    check("midrst paging3", pg3, 8'h00);
    check("midrst ay_addr3", aa3, 4'h0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("postrst border3", brd3, 3'd2);
    check("postrst border5", brd5, 3'd2);
    D = 8'h05;
    repeat (2) @(negedge clk);
    check("held border3", brd3, 3'd2);
    nIORQ = 1'b1; nWR = 1'b1;
    repeat (2) @(negedge clk);
    io_wr(16'h7FFD, 8'h10, 2);
    check("unlock paging3", pg3, 8'h10);
    check("unlock paging5", pg5, 8'h10);
    A = 16'h00FE; D = 8'h01; nIORQ = 1'b0; nWR = 1'b0;
    repeat (2) @(negedge clk);
    nIORQ = 1'b1; nWR = 1'b1;
    check("b2b first border3", brd3, 3'd1);
    @(negedge clk);
    D = 8'h06; nIORQ = 1'b0; nWR = 1'b0;
    repeat (2) @(negedge clk);
    nIORQ = 1'b1; nWR = 1'b1;
    repeat (2) @(negedge clk);
    check("b2b second border3", brd3, 3'd6);
    check("b2b second speaker3", spk3, 1'b0);
    #1;
    A = 16'h4000; nIORQ = 1'b0; nWR = 1'b0;
    #1;
    check("io ram_we3", we3, 1'b0);
    nIORQ = 1'b1; nWR = 1'b1;
    A = 16'h1234; nMREQ = 1'b0; nWR = 1'b0;
    #1;
    check("romwr ram_we3", we3, 1'b0);
    check("romwr ram_we5", we5, 1'b0);
    check("romwr rom_sel3", rsel3, 1'b1);
    check("romwr rom_addr3", rom3, 15'h5234);
    A = 16'h4000;
    #1;
    check("ramwr ram_we3", we3, 1'b1);
    check("ramwr ram_we5", we5, 1'b1);
    check("ramwr rom_sel3", rsel3, 1'b0);
    check("ramwr mem3", mem3, 17'h14000);
    check("ramwr mem5", mem5, 19'h14000);
    nWR = 1'b1; nRD = 1'b0;
    #1;
    check("ramrd ram_we3", we3, 1'b0);
    nMREQ = 1'b1; nRD = 1'b1;
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
